// File: rtl/rwg_seq_ctrl.sv
// Row/column sequencer for the 11-bit random weight generator LFSR: seeds each row, then streams
// weights over valid/ready. Optional LFSR lock-up guard enabled by defining RWG_ZERO_GUARD_EN.
module rwg_seq_ctrl #(
  parameter int NUM_ROWS        = 12,
  parameter int WEIGHTS_PER_ROW = 11,
  parameter int LFSR_W          = 11,
  parameter int ROW_W           = 4,
  parameter int COL_W           = 4
) (
  input  logic              clk2,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              seed_load,
  output logic [ROW_W-1:0]  seed_sel,
  output logic              lfsr_step,
  input  logic [LFSR_W-1:0] lfsr_value,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [LFSR_W-1:0] w_data,
  output logic [ROW_W-1:0]  w_row,
  output logic [COL_W-1:0]  w_col
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EMIT,
    S_DONE
`ifdef RWG_ZERO_GUARD_EN
    , S_ERR
`endif
  } state_t;

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WEIGHTS_PER_ROW - 1);

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             zero_lock;
  logic             accept;

  // An all-zero LFSR never leaves zero, so that value is treated as a lock-up, not a weight.
`ifdef RWG_ZERO_GUARD_EN
  assign zero_lock = (lfsr_value == '0);
`else
  assign zero_lock = 1'b0;
`endif

  assign w_valid   = (state_q == S_EMIT) && !zero_lock;
  assign accept    = w_valid && w_ready;
  assign lfsr_step = accept;
  assign w_data    = lfsr_value;
  assign w_row     = row_q;
  assign w_col     = col_q;
  assign seed_sel  = row_q;
  assign seed_load = (state_q == S_LOAD);
  assign busy      = (state_q == S_LOAD) || (state_q == S_EMIT);
  assign done      = (state_q == S_DONE);
`ifdef RWG_ZERO_GUARD_EN
  assign err       = (state_q == S_ERR);
`else
  assign err       = 1'b0;
`endif

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          row_d   = '0;
          col_d   = '0;
        end
      end
      S_LOAD: state_d = S_EMIT;
      S_EMIT: begin
        if (zero_lock) begin
`ifdef RWG_ZERO_GUARD_EN
          state_d = S_ERR;
`endif
        end else if (accept) begin
          if (col_q != COL_LAST) begin
            col_d = col_q + COL_W'(1);
          end else if (row_q != ROW_LAST) begin
            col_d   = '0;
            row_d   = row_q + ROW_W'(1);
            state_d = S_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
`ifdef RWG_ZERO_GUARD_EN
      // ERR behaves like IDLE for start; leaving it is what clears err.
      S_ERR: begin
        if (start) begin
          state_d = S_LOAD;
          row_d   = '0;
          col_d   = '0;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

endmodule

// File: tb/tb_rwg_seq_ctrl.sv
// Directed self-checking bench for rwg_seq_ctrl: full runs, random back-pressure, mid-run reset,
// held start, a 1x1 configuration and the forced-zero LFSR case (both builds).
module tb_rwg_seq_ctrl;

  localparam int NR = 12;
  localparam int NW = 11;

  logic        clk2 = 1'b0;
  logic        rst  = 1'b1;
  logic        start = 1'b0;
  logic        w_ready = 1'b0;
  logic        busy, done, err, seed_load, lfsr_step, w_valid;
  logic [3:0]  seed_sel, w_row, w_col;
  logic [10:0] lfsr_value, w_data;
  logic [10:0] lfsr_q = 11'h001;
  logic        zero_en = 1'b0;

  logic        s_start = 1'b0;
  logic        s_ready = 1'b0;
  logic        s_busy, s_done, s_err, s_seed_load, s_lfsr_step, s_w_valid;
  logic [0:0]  s_seed_sel, s_w_row, s_w_col;
  logic [10:0] s_w_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk2 = ~clk2;

  rwg_seq_ctrl u_dut (
    .clk2(clk2), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .seed_load(seed_load), .seed_sel(seed_sel), .lfsr_step(lfsr_step),
    .lfsr_value(lfsr_value), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .w_row(w_row), .w_col(w_col)
  );

  rwg_seq_ctrl #(.NUM_ROWS(1), .WEIGHTS_PER_ROW(1), .LFSR_W(11), .ROW_W(1), .COL_W(1)) u_small (
    .clk2(clk2), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done), .err(s_err),
    .seed_load(s_seed_load), .seed_sel(s_seed_sel), .lfsr_step(s_lfsr_step),
    .lfsr_value(11'h5A5), .w_valid(s_w_valid), .w_ready(s_ready), .w_data(s_w_data),
    .w_row(s_w_row), .w_col(s_w_col)
  );

  function automatic logic [10:0] seed_of(input logic [3:0] s);
    return 11'(int'(s) * 97 + 1);
  endfunction

  function automatic logic [10:0] lfsr_next(input logic [10:0] q);
    return {q[9:0], q[10] ^ q[8]};
  endfunction

  function automatic logic [10:0] nth(input logic [10:0] seed, input int n);
    logic [10:0] q = seed;
    for (int i = 0; i < n; i++) q = lfsr_next(q);
    return q;
  endfunction

  // LFSR model standing in for the real generator, with an optional forced lock-up at row 2 col 4.
  always_ff @(posedge clk2) begin
    if (seed_load)      lfsr_q <= seed_of(seed_sel);
    else if (lfsr_step) lfsr_q <= lfsr_next(lfsr_q);
  end
  assign lfsr_value = (zero_en && w_row == 4'd2 && w_col == 4'd4) ? 11'h000 : lfsr_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic pick_ready(input int mode);
    if (mode == 0) return 1'b1;
    return ($urandom % 3) != 0;
  endfunction

  // One run from a start pulse. abort: reset while stalled at row 5 col 3. zero: lock-up at row 2 col 4.
  task automatic do_run(input int mode, input bit hold, input bit abort, input bit zero,
                        output bit guard_hit);
    int  row = 0, col = 0, cyc = 0, beats = 0, loads = 0, stalls = 0;
    bit  in_load = 1'b1, exp_done = 1'b0, fin = 1'b0;
    logic [10:0] exp_data;
    guard_hit = 1'b0;
    zero_en   = zero;
    @(negedge clk2);
    start = 1'b1;
    @(negedge clk2);
    start = hold;
    while (!fin && cyc < 3000) begin
      if (cyc > 0) @(negedge clk2);
      w_ready = (abort && row == 5 && col == 3) ? 1'b0 : pick_ready(mode);
      #1;
      if (in_load) begin
        check("load", {busy, seed_load, w_valid, lfsr_step, done, seed_sel},
              {5'b11000, 4'(row)});
        loads++;
        in_load = 1'b0;
      end else if (exp_done) begin
        check("done", {done, busy, w_valid, seed_load}, 4'b1000);
        check("done_err", err, 1'b0);
        if (mode == 0) check("done_cycle", cyc, NR * (NW + 1));
        check("beat_count", beats, NR * NW);
        check("load_count", loads, NR);
        fin = 1'b1;
`ifdef RWG_ZERO_GUARD_EN
      end else if (zero && row == 2 && col == 4) begin
        check("zero_block", {w_valid, lfsr_step, busy}, 3'b001);
        guard_hit = 1'b1;
        fin = 1'b1;
`endif
      end else begin
        exp_data = (zero && row == 2 && col == 4) ? 11'h000 : nth(seed_of(4'(row)), col);
        check("beat", {w_valid, w_row, w_col, w_data}, {1'b1, 4'(row), 4'(col), exp_data});
        check("step", {done, seed_load, lfsr_step}, {2'b00, w_ready});
        if (abort && row == 5 && col == 3) begin
          stalls++;
          if (stalls == 3) begin
            #1 rst = 1'b1;
            #1;
            check("mid_rst", {busy, done, err, seed_load, lfsr_step, w_valid, seed_sel, w_row, w_col}, 0);
            @(negedge clk2);
            rst = 1'b0;
            fin = 1'b1;
          end
        end else if (w_ready) begin
          beats++;
          if (col < NW - 1) col++;
          else begin
            col = 0;
            if (row < NR - 1) begin
              row++;
              in_load = 1'b1;
            end else exp_done = 1'b1;
          end
        end
      end
      cyc++;
    end
    if (!fin) check("timeout", 0, 1);
    zero_en = 1'b0;
  endtask

  task automatic pulse_rst();
    @(negedge clk2);
    rst = 1'b1;
    @(negedge clk2);
    rst = 1'b0;
  endtask

  initial begin
    bit hit;
    #2;
    check("reset", {busy, done, err, seed_load, lfsr_step, w_valid, seed_sel, w_row, w_col}, 0);
    check("reset_small", {s_busy, s_done, s_err, s_seed_load, s_w_valid}, 0);
    @(negedge clk2);
    rst = 1'b0;

    do_run(0, 1'b0, 1'b0, 1'b0, hit);     // back-to-back beats, exact timing
    do_run(1, 1'b0, 1'b0, 1'b0, hit);     // random back-pressure
    do_run(1, 1'b0, 1'b1, 1'b0, hit);     // reset while stalled at row 5 col 3
    do_run(0, 1'b0, 1'b0, 1'b0, hit);     // restart after reset begins at row 0 col 0

    // start held high: one run, then DONE -> IDLE -> new LOAD
    do_run(0, 1'b1, 1'b0, 1'b0, hit);
    @(negedge clk2); #1;
    check("hold_idle", {busy, done, seed_load}, 3'b000);
    @(negedge clk2); #1;
    check("hold_restart", {busy, seed_load, seed_sel}, {2'b11, 4'd0});
    start = 1'b0;
    pulse_rst();

    // 1x1 configuration
    @(negedge clk2);
    s_start = 1'b1;
    s_ready = 1'b1;
    @(negedge clk2); #1;
    s_start = 1'b0;
    check("small_load", {s_seed_load, s_seed_sel, s_w_valid, s_busy}, 4'b1001);
    @(negedge clk2); #1;
    check("small_beat", {s_w_valid, s_lfsr_step, s_w_row, s_w_col, s_w_data}, {4'b1100, 11'h5A5});
    @(negedge clk2); #1;
    check("small_done", {s_done, s_busy, s_w_valid, s_seed_load}, 4'b1000);
    @(negedge clk2); #1;
    check("small_idle", {s_done, s_busy}, 2'b00);
    s_ready = 1'b0;

    // forced zero at row 2 col 4
    do_run(0, 1'b0, 1'b0, 1'b1, hit);
`ifdef RWG_ZERO_GUARD_EN
    check("guard_hit", hit, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk2); #1;
      check("err_sticky", {err, busy, done, w_valid}, 4'b1000);
    end
    start = 1'b1;
    @(negedge clk2); #1;
    start = 1'b0;
    check("err_clear", {err, seed_load, seed_sel}, {2'b01, 4'd0});
    pulse_rst();
`else
    check("no_guard", {hit, err}, 2'b00);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
